// File: rtl/bpu_update_arbiter.sv
// Merges ROB-committed branch updates and buffered predecoder BTB learn requests
// onto single registered PHT and BTB write ports. ROB JIRL writes pre-empt the FIFO.
module bpu_update_arbiter #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     isBranch_rob,
    input  logic                     Branch_rob,
    input  logic                     isJIRL_rob,
    input  logic [31:0]              pc_rob,
    input  logic [31:0]              target_rob,
    input  logic [3:0]               isBranch,
    input  logic [3:0]               dontWriteJIRL,
    input  logic [3:0][31:0]         pc_write,
    input  logic [3:0][31:0]         target_write,
    output logic                     pd_ready,
    output logic                     pht_we,
    output logic [31:0]              pht_pc,
    output logic                     pht_taken,
    output logic                     btb_we,
    output logic [31:0]              btb_pc,
    output logic [31:0]              btb_target,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         stall_cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 4);

    logic [63:0]      mem [DEPTH];
    logic [AW-1:0]    head_reg, tail_reg;
    logic [AW:0]      count_reg, count_next;
    logic [CNT_W-1:0] stall_reg;
    logic [3:0]       lane_valid;
    logic [AW-1:0]    lane_addr [4];
    logic [AW:0]      n_enq;
    logic             rob_jirl, do_enq, do_pop;

    assign lane_valid = isBranch & ~dontWriteJIRL;
    assign n_enq      = (AW+1)'($countones(lane_valid));

    // Each valid lane lands at tail + (number of valid lanes below it), packing them densely.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [3:0] BELOW = 4'((1 << gi) - 1);
            assign lane_addr[gi] = tail_reg + AW'($countones(lane_valid & BELOW));
        end
    endgenerate

    assign pd_ready = (count_reg <= READY_MAX);
    assign rob_jirl = isBranch_rob & isJIRL_rob;
    assign do_enq   = pd_ready & ~flush;
    assign do_pop   = ~rob_jirl & ~flush & (count_reg != '0);

    always_comb begin
        count_next = count_reg;
        if (do_enq) begin
            count_next = count_next + n_enq;
        end
        if (do_pop) begin
            count_next = count_next - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_valid[i]) begin
                    mem[lane_addr[i]] <= {pc_write[i], target_write[i]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            stall_reg  <= '0;
            pht_we     <= 1'b0;
            pht_pc     <= '0;
            pht_taken  <= 1'b0;
            btb_we     <= 1'b0;
            btb_pc     <= '0;
            btb_target <= '0;
        end else begin
            pht_we <= isBranch_rob;
            if (isBranch_rob) begin
                pht_pc    <= pc_rob;
                pht_taken <= Branch_rob;
            end

            btb_we <= rob_jirl | do_pop;
            if (rob_jirl) begin
                btb_pc     <= pc_rob;
                btb_target <= target_rob;
            end else if (do_pop) begin
                btb_pc     <= mem[head_reg][63:32];
                btb_target <= mem[head_reg][31:0];
            end

            if (flush) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (do_pop) begin
                    head_reg <= head_reg + 1'b1;
                end
                if (do_enq) begin
                    tail_reg <= tail_reg + AW'(n_enq);
                end
                count_reg <= count_next;
            end

            if (!pd_ready && stall_reg != '1) begin
                stall_reg <= stall_reg + 1'b1;
            end
        end
    end

    assign fifo_count   = count_reg;
    assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_bpu_update_arbiter.sv
// Randomized and directed stimulus against a queue-based reference model; expected
// outputs are queued per cycle and checked by an independent monitor.
module tb_bpu_update_arbiter;

    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst, flush, isBranch_rob, Branch_rob, isJIRL_rob;
    logic [31:0]       pc_rob, target_rob;
    logic [3:0]        isBranch, dontWriteJIRL;
    logic [3:0][31:0]  pc_write, target_write;

    logic              pd_ready, pht_we, pht_taken, btb_we;
    logic [31:0]       pht_pc, btb_pc, btb_target;
    logic [3:0]        fifo_count;
    logic [15:0]       stall_cycles;

    logic              pd_ready4, pht_we4, pht_taken4, btb_we4;
    logic [31:0]       pht_pc4, btb_pc4, btb_target4;
    logic [3:0]        fifo_count4;
    logic [3:0]        stall_cycles4;

    bpu_update_arbiter #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .isBranch_rob(isBranch_rob), .Branch_rob(Branch_rob), .isJIRL_rob(isJIRL_rob),
        .pc_rob(pc_rob), .target_rob(target_rob),
        .isBranch(isBranch), .dontWriteJIRL(dontWriteJIRL),
        .pc_write(pc_write), .target_write(target_write),
        .pd_ready(pd_ready), .pht_we(pht_we), .pht_pc(pht_pc), .pht_taken(pht_taken),
        .btb_we(btb_we), .btb_pc(btb_pc), .btb_target(btb_target),
        .fifo_count(fifo_count), .stall_cycles(stall_cycles)
    );

    bpu_update_arbiter #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .isBranch_rob(isBranch_rob), .Branch_rob(Branch_rob), .isJIRL_rob(isJIRL_rob),
        .pc_rob(pc_rob), .target_rob(target_rob),
        .isBranch(isBranch), .dontWriteJIRL(dontWriteJIRL),
        .pc_write(pc_write), .target_write(target_write),
        .pd_ready(pd_ready4), .pht_we(pht_we4), .pht_pc(pht_pc4), .pht_taken(pht_taken4),
        .btb_we(btb_we4), .btb_pc(btb_pc4), .btb_target(btb_target4),
        .fifo_count(fifo_count4), .stall_cycles(stall_cycles4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pht_we;
        logic [31:0] pht_pc;
        logic        pht_taken;
        logic        btb_we;
        logic [31:0] btb_pc;
        logic [31:0] btb_target;
        int          count;
        int          stall16;
        int          stall4;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model_q[$];
    logic [31:0] m_pht_pc, m_btb_pc, m_btb_tgt;
    logic        m_pht_taken;
    int          m_stall16, m_stall4;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic clear_inputs();
        rst = 0; flush = 0; isBranch_rob = 0; Branch_rob = 0; isJIRL_rob = 0;
        pc_rob = '0; target_rob = '0; isBranch = '0; dontWriteJIRL = '0;
        pc_write = '0; target_write = '0;
    endtask

    task automatic rand_lanes(input logic [3:0] br, input logic [3:0] dw);
        isBranch = br;
        dontWriteJIRL = dw;
        for (int i = 0; i < 4; i++) begin
            pc_write[i] = $urandom & 32'hFFFF_FFFC;
            target_write[i] = $urandom;
        end
    endtask

    // Evaluate the model for the inputs currently applied, queue the expected outputs,
    // then advance to the next falling edge.
    task automatic run_cycle();
        exp_t        e;
        logic [63:0] ent;
        bit          ready;
        if (rst) begin
            model_q.delete();
            m_pht_pc = '0; m_pht_taken = 0; m_btb_pc = '0; m_btb_tgt = '0;
            m_stall16 = 0; m_stall4 = 0;
            e.pht_we = 0;
            e.btb_we = 0;
        end else begin
            ready = (DEPTH - model_q.size()) >= 4;
            check("pd_ready", {63'd0, pd_ready}, {63'd0, ready});
            check("pd_ready_cnt4", {63'd0, pd_ready4}, {63'd0, ready});
            e.pht_we = isBranch_rob;
            if (isBranch_rob) begin
                m_pht_pc = pc_rob;
                m_pht_taken = Branch_rob;
            end
            if (isBranch_rob && isJIRL_rob) begin
                e.btb_we = 1;
                m_btb_pc = pc_rob;
                m_btb_tgt = target_rob;
            end else if (model_q.size() > 0 && !flush) begin
                ent = model_q.pop_front();
                e.btb_we = 1;
                m_btb_pc = ent[63:32];
                m_btb_tgt = ent[31:0];
            end else begin
                e.btb_we = 0;
            end
            if (ready && !flush) begin
                for (int i = 0; i < 4; i++) begin
                    if (isBranch[i] && !dontWriteJIRL[i]) begin
                        model_q.push_back({pc_write[i], target_write[i]});
                    end
                end
            end
            if (flush) model_q.delete();
            if (!ready) begin
                if (m_stall16 < 65535) m_stall16++;
                if (m_stall4 < 15) m_stall4++;
            end
        end
        e.pht_pc = m_pht_pc;
        e.pht_taken = m_pht_taken;
        e.btb_pc = m_btb_pc;
        e.btb_target = m_btb_tgt;
        e.count = model_q.size();
        e.stall16 = m_stall16;
        e.stall4 = m_stall4;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pht_we", {63'd0, pht_we}, {63'd0, e.pht_we});
            if (e.pht_we) begin
                check("pht_pc", {32'd0, pht_pc}, {32'd0, e.pht_pc});
                check("pht_taken", {63'd0, pht_taken}, {63'd0, e.pht_taken});
            end
            check("btb_we", {63'd0, btb_we}, {63'd0, e.btb_we});
            check("btb_pc", {32'd0, btb_pc}, {32'd0, e.btb_pc});
            check("btb_target", {32'd0, btb_target}, {32'd0, e.btb_target});
            check("fifo_count", {60'd0, fifo_count}, 64'(e.count));
            check("stall_cycles", {48'd0, stall_cycles}, 64'(e.stall16));
            check("stall_cycles_cnt4", {60'd0, stall_cycles4}, 64'(e.stall4));
            if (btb_we) $display("btb write pc=%h target=%h count=%0d", btb_pc, btb_target, fifo_count);
        end
    end

    initial begin
        clear_inputs();
        @(negedge clk);

        // reset with all lanes valid
        rst = 1;
        rand_lanes(4'hF, 4'h0);
        run_cycle();
        run_cycle();
        clear_inputs();
        run_cycle();

        // lane compaction: lane 1 suppressed
        isBranch = 4'hF; dontWriteJIRL = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            pc_write[i] = 32'h100 + 32'(4 * i);
            target_write[i] = 32'hA000 + 32'(4 * i);
        end
        run_cycle();
        clear_inputs();
        repeat (5) run_cycle();

        // back-pressure
        repeat (12) begin rand_lanes(4'hF, 4'h0); run_cycle(); end
        clear_inputs();
        repeat (10) run_cycle();

        // ROB JIRL priority over queued entries
        rand_lanes(4'hF, 4'h0); run_cycle();
        clear_inputs(); run_cycle();
        isBranch_rob = 1; isJIRL_rob = 1; Branch_rob = 1;
        pc_rob = 32'h2000; target_rob = 32'h3000;
        run_cycle();
        clear_inputs();
        repeat (6) run_cycle();

        // flush with full-width lanes in the same cycle
        repeat (2) begin rand_lanes(4'hF, 4'h0); run_cycle(); end
        rand_lanes(4'hF, 4'h0); flush = 1;
        run_cycle();
        clear_inputs();
        repeat (4) run_cycle();

        // one-in one-out across pointer wrap
        repeat (3 * DEPTH) begin
            rand_lanes(4'(1 << $urandom_range(0, 3)), 4'h0);
            run_cycle();
        end
        clear_inputs();
        repeat (4) run_cycle();

        // ROB JIRL every cycle blocks draining; stall counters saturate
        repeat (25) begin
            rand_lanes(4'hF, 4'h0);
            isBranch_rob = 1; isJIRL_rob = 1; Branch_rob = 1'($urandom);
            pc_rob = $urandom; target_rob = $urandom;
            run_cycle();
        end
        clear_inputs();
        repeat (10) run_cycle();

        // random traffic including occasional flush and mid-operation reset
        repeat (400) begin
            rand_lanes(4'($urandom), 4'($urandom));
            isBranch_rob = 1'($urandom);
            isJIRL_rob = ($urandom_range(0, 9) < 3);
            Branch_rob = 1'($urandom);
            pc_rob = $urandom; target_rob = $urandom;
            flush = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            run_cycle();
        end
        clear_inputs();
        repeat (12) run_cycle();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected cycles unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
